// File: rtl/cw_output_arbiter_if.sv
// rtl/cw_output_arbiter_if.sv - CW output arbiter requester/downstream bundle
// Requesters and the downstream link sit on the master side; the arbiter is the slave.
interface cw_output_arbiter_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  polarity;
    logic                  req_cw_even;
    logic                  req_cw_odd;
    logic                  req_pe_even;
    logic                  req_pe_odd;
    logic [DATA_WIDTH-1:0] data_cw_even;
    logic [DATA_WIDTH-1:0] data_cw_odd;
    logic [DATA_WIDTH-1:0] data_pe_even;
    logic [DATA_WIDTH-1:0] data_pe_odd;
    logic                  gnt_cw_even;
    logic                  gnt_cw_odd;
    logic                  gnt_pe_even;
    logic                  gnt_pe_odd;
    logic                  cwso;
    logic                  cwro;
    logic [DATA_WIDTH-1:0] cwdo;

    modport master (
        input  polarity, gnt_cw_even, gnt_cw_odd, gnt_pe_even, gnt_pe_odd, cwso, cwdo,
        output req_cw_even, req_cw_odd, req_pe_even, req_pe_odd,
        output data_cw_even, data_cw_odd, data_pe_even, data_pe_odd, cwro
    );

    modport slave (
        output polarity, gnt_cw_even, gnt_cw_odd, gnt_pe_even, gnt_pe_odd, cwso, cwdo,
        input  req_cw_even, req_cw_odd, req_pe_even, req_pe_odd,
        input  data_cw_even, data_cw_odd, data_pe_even, data_pe_odd, cwro
    );
endinterface

// File: rtl/cw_output_arbiter.sv
// rtl/cw_output_arbiter.sv - CW link output arbiter with per-VC round-robin and one-packet buffers
// Index 0 of every per-VC array is the even VC, index 1 the odd VC.
module cw_output_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int HOP_MSB    = 55,
    parameter int HOP_LSB    = 48
) (
    input logic                 clk,
    input logic                 rst,
    cw_output_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        GRANT = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q    [2];
    logic                  ptr_pe_q   [2];
    logic                  gnt_cw_q   [2];
    logic                  gnt_pe_q   [2];
    logic [DATA_WIDTH-1:0] buf_q      [2];
    logic                  polarity_q;
    logic                  cwso_q;
    logic [DATA_WIDTH-1:0] cwdo_q;

    logic                  req_cw     [2];
    logic                  req_pe     [2];
    logic [DATA_WIDTH-1:0] data_cw    [2];
    logic [DATA_WIDTH-1:0] data_pe    [2];

    assign req_cw[0]  = bus.req_cw_even;
    assign req_cw[1]  = bus.req_cw_odd;
    assign req_pe[0]  = bus.req_pe_even;
    assign req_pe[1]  = bus.req_pe_odd;
    assign data_cw[0] = bus.data_cw_even;
    assign data_cw[1] = bus.data_cw_odd;
    assign data_pe[0] = bus.data_pe_even;
    assign data_pe[1] = bus.data_pe_odd;

    // Each hop consumed on the CW link halves the hop field; other bits pass untouched.
    function automatic logic [DATA_WIDTH-1:0] hop_shift(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = d;
        r[HOP_MSB:HOP_LSB] = d[HOP_MSB:HOP_LSB] >> 1;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            polarity_q <= 1'b0;
            cwso_q     <= 1'b0;
            cwdo_q     <= '0;
            for (int v = 0; v < 2; v++) begin
                state_q[v]  <= EMPTY;
                ptr_pe_q[v] <= 1'b0;
                gnt_cw_q[v] <= 1'b0;
                gnt_pe_q[v] <= 1'b0;
                buf_q[v]    <= '0;
            end
        end else begin
            polarity_q <= ~polarity_q;
            cwso_q     <= 1'b0;
            for (int v = 0; v < 2; v++) begin
                case (state_q[v])
                    EMPTY: begin
                        if (req_cw[v] || req_pe[v]) begin
                            state_q[v] <= GRANT;
                            if (req_cw[v] && (!req_pe[v] || !ptr_pe_q[v])) begin
                                gnt_cw_q[v] <= 1'b1;
                                ptr_pe_q[v] <= 1'b1;
                            end else begin
                                gnt_pe_q[v] <= 1'b1;
                                ptr_pe_q[v] <= 1'b0;
                            end
                        end
                    end
                    GRANT: begin
                        buf_q[v]    <= gnt_cw_q[v] ? data_cw[v] : data_pe[v];
                        gnt_cw_q[v] <= 1'b0;
                        gnt_pe_q[v] <= 1'b0;
                        state_q[v]  <= FULL;
                    end
                    FULL: begin
                        // Polarity parity makes the two VCs mutually exclusive on cwso/cwdo.
                        if ((polarity_q == v[0]) && bus.cwro) begin
                            cwso_q     <= 1'b1;
                            cwdo_q     <= hop_shift(buf_q[v]);
                            state_q[v] <= EMPTY;
                        end
                    end
                    default: begin
                        state_q[v] <= EMPTY;
                    end
                endcase
            end
        end
    end

    assign bus.polarity    = polarity_q;
    assign bus.gnt_cw_even = gnt_cw_q[0];
    assign bus.gnt_cw_odd  = gnt_cw_q[1];
    assign bus.gnt_pe_even = gnt_pe_q[0];
    assign bus.gnt_pe_odd  = gnt_pe_q[1];
    assign bus.cwso        = cwso_q;
    assign bus.cwdo        = cwdo_q;
endmodule

// File: tb/tb_cw_output_arbiter.sv
// tb/tb_cw_output_arbiter.sv - directed and randomized bench for cw_output_arbiter
// Requester index r: 0 cw_even, 1 cw_odd, 2 pe_even, 3 pe_odd (VC = r%2, partner = r^2).
module tb_cw_output_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cwro_r = 1'b0;
    logic        req [4];
    logic [63:0] dat [4];
    logic [3:0]  dut_gnt;

    int vectors = 0;
    int miscompares = 0;

    logic        m_pol;
    logic        m_cwso;
    logic [63:0] m_cwdo;
    logic        m_gnt [4];
    logic        m_full [2];
    logic [63:0] m_pkt [2];
    logic        m_fav_pe [2];

    cw_output_arbiter_if #(.DATA_WIDTH(64)) bus ();

    cw_output_arbiter #(.DATA_WIDTH(64), .HOP_MSB(55), .HOP_LSB(48)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.req_cw_even  = req[0];
    assign bus.req_cw_odd   = req[1];
    assign bus.req_pe_even  = req[2];
    assign bus.req_pe_odd   = req[3];
    assign bus.data_cw_even = dat[0];
    assign bus.data_cw_odd  = dat[1];
    assign bus.data_pe_even = dat[2];
    assign bus.data_pe_odd  = dat[3];
    assign bus.cwro         = cwro_r;
    assign dut_gnt = {bus.gnt_pe_odd, bus.gnt_pe_even, bus.gnt_cw_odd, bus.gnt_cw_even};

    function automatic logic [63:0] ref_shift(input logic [63:0] p);
        logic [63:0] hop;
        hop = (p >> 48) & 64'hFF;
        return (p & ~(64'hFF << 48)) | ((hop / 2) << 48);
    endfunction

    // Behavioural model: a VC holding a grant captures the winner's data, a loaded VC
    // waits for its polarity with cwro, an idle VC arbitrates among live requests.
    task automatic model_step();
        logic        n_cwso;
        logic [63:0] n_cwdo;
        int          pick;
        if (rst) begin
            m_pol = 0; m_cwso = 0; m_cwdo = 0;
            for (int r = 0; r < 4; r++) m_gnt[r] = 0;
            for (int v = 0; v < 2; v++) begin m_full[v] = 0; m_pkt[v] = 0; m_fav_pe[v] = 0; end
        end else begin
            n_cwso = 0;
            n_cwdo = m_cwdo;
            for (int v = 0; v < 2; v++) begin
                if (m_gnt[v] || m_gnt[v+2]) begin
                    m_pkt[v]  = m_gnt[v] ? dat[v] : dat[v+2];
                    m_full[v] = 1;
                    m_gnt[v] = 0; m_gnt[v+2] = 0;
                end else if (m_full[v]) begin
                    if (int'(m_pol) == v && cwro_r) begin
                        n_cwso = 1;
                        n_cwdo = ref_shift(m_pkt[v]);
                        m_full[v] = 0;
                    end
                end else if (req[v] || req[v+2]) begin
                    pick = (req[v] && !(req[v+2] && m_fav_pe[v])) ? v : v + 2;
                    m_gnt[pick] = 1;
                    m_fav_pe[v] = (pick == v);
                end
            end
            m_pol  = ~m_pol;
            m_cwso = n_cwso;
            m_cwdo = n_cwdo;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("polarity", {63'd0, bus.polarity}, {63'd0, m_pol});
        chk("gnt_cw_even", {63'd0, bus.gnt_cw_even}, {63'd0, m_gnt[0]});
        chk("gnt_cw_odd", {63'd0, bus.gnt_cw_odd}, {63'd0, m_gnt[1]});
        chk("gnt_pe_even", {63'd0, bus.gnt_pe_even}, {63'd0, m_gnt[2]});
        chk("gnt_pe_odd", {63'd0, bus.gnt_pe_odd}, {63'd0, m_gnt[3]});
        chk("cwso", {63'd0, bus.cwso}, {63'd0, m_cwso});
        chk("cwdo", bus.cwdo, m_cwdo);
    endtask

    task automatic react();
        for (int r = 0; r < 4; r++) if (m_gnt[r]) req[r] = 0;
    endtask

    initial begin
        int          seen;
        int          ng;
        int          k;
        logic [63:0] got;
        int          q[$];
        int          w[3];
        int          idx[$];

        for (int r = 0; r < 4; r++) begin req[r] = 0; dat[r] = 0; end
        rst = 1;
        cwro_r = 0;

        // Reset, then polarity alternation
        cycle();
        cycle();
        chk("reset_polarity", {63'd0, bus.polarity}, 64'd0);
        chk("reset_cwdo", bus.cwdo, 64'd0);
        rst = 0;
        for (int i = 0; i < 4; i++) cycle();

        // Single even packet with hop shift
        cwro_r = 1;
        req[0] = 1;
        dat[0] = 64'h00F0_0000_0000_00AA;
        seen = 0; ng = 0; got = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (bus.cwso) begin seen++; got = bus.cwdo; end
            if (dut_gnt[0]) ng++;
            react();
        end
        chk("even_cwso_count", 64'(seen), 64'd1);
        chk("even_gnt_count", 64'(ng), 64'd1);
        chk("even_cwdo_value", got, 64'h0078_0000_0000_00AA);

        // Round-robin on the odd VC with persistent re-requests
        req[1] = 1; dat[1] = 64'h0011_2233_4455_6677;
        req[3] = 1; dat[3] = 64'h00AA_BBCC_DDEE_FF00;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (dut_gnt[1]) q.push_back(1);
            if (dut_gnt[3]) q.push_back(3);
            req[1] = !m_gnt[1];
            req[3] = !m_gnt[3];
        end
        req[1] = 0; req[3] = 0;
        for (int i = 0; i < 3; i++) w[i] = (q.size() > i) ? q[i] : 0;
        chk("rr_first", 64'(w[0]), 64'd1);
        chk("rr_second", 64'(w[1]), 64'd3);
        chk("rr_third", 64'(w[2]), 64'd1);
        for (int i = 0; i < 8; i++) begin cycle(); react(); end

        // Odd buffer full with downstream stalled
        req[1] = 1; dat[1] = {$urandom, $urandom};
        k = 0;
        do begin cycle(); k++; end while (!bus.gnt_cw_odd && k < 6);
        chk("stall_grant_seen", {63'd0, bus.gnt_cw_odd}, 64'd1);
        req[1] = 0;
        req[3] = 1; dat[3] = {$urandom, $urandom};
        cwro_r = 0;
        cycle();
        seen = 0; ng = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (bus.cwso) seen++;
            if (dut_gnt[1] || dut_gnt[3]) ng++;
        end
        chk("stall_no_cwso", 64'(seen), 64'd0);
        chk("stall_no_gnt", 64'(ng), 64'd0);
        cwro_r = 1;
        seen = 0; ng = 0;
        for (int i = 0; i < 2; i++) begin cycle(); if (bus.cwso) seen++; if (dut_gnt[3]) ng++; react(); end
        chk("unstall_cwso", 64'(seen), 64'd1);
        for (int i = 0; i < 4; i++) begin cycle(); if (dut_gnt[3]) ng++; react(); end
        chk("unstall_next_gnt", 64'(ng), 64'd1);
        for (int i = 0; i < 6; i++) begin cycle(); react(); end

        // Both VCs full, then drained back to back
        cwro_r = 0;
        req[0] = 1; dat[0] = {$urandom, $urandom};
        req[1] = 1; dat[1] = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin cycle(); react(); end
        cwro_r = 1;
        for (int i = 0; i < 4; i++) begin cycle(); if (bus.cwso) idx.push_back(i); end
        chk("both_send_count", 64'(idx.size()), 64'd2);
        chk("both_send_consecutive", 64'((idx.size() == 2) ? idx[1] - idx[0] : 0), 64'd1);

        // Reset while the odd VC is in GRANT
        req[3] = 1; dat[3] = {$urandom, $urandom};
        k = 0;
        do begin cycle(); k++; end while (!bus.gnt_pe_odd && k < 6);
        chk("rst_grant_seen", {63'd0, bus.gnt_pe_odd}, 64'd1);
        rst = 1; req[3] = 0;
        cycle();
        chk("rst_gnt_cleared", {63'd0, bus.gnt_pe_odd}, 64'd0);
        rst = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin cycle(); if (bus.cwso) seen++; end
        chk("rst_dropped_packet", 64'(seen), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle();
            react();
            for (int r = 0; r < 4; r++) begin
                if (!req[r] && !m_gnt[r] && $urandom_range(2) == 0) begin
                    req[r] = 1;
                    dat[r] = {$urandom, $urandom};
                end
            end
            cwro_r = ($urandom_range(3) != 0);
            rst = ($urandom_range(99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
